// File: rtl/pwm_cmp8.sv
// PWM comparator fed by an upstream free-running 8-bit counter. Duty updates arrive over
// valid/ready and take effect only at a period boundary; also counts periods and checks sync.
module pwm_cmp8 #(
  parameter bit          ACTIVE_HIGH = 1'b1,
  parameter logic [7:0]  DUTY_INIT   = 8'd0,
  parameter int unsigned PCNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [7:0]        cnt_in,
  input  logic              cnt_wrap,
  input  logic              duty_valid,
  input  logic [7:0]        duty_data,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              applied,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              sync_err
);

  localparam logic IdleLvl = ~ACTIVE_HIGH;

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e            state_q, state_d;
  logic [7:0]        pending_q, pending_d;
  logic [7:0]        active_duty_q, active_duty_d;
  logic [7:0]        prev_cnt_q, prev_cnt_d;
  logic              pwm_q, pwm_d;
  logic              applied_q, applied_d;
  logic              sync_err_q, sync_err_d;
  logic              armed_q, armed_d;
  logic [PCNT_W-1:0] period_cnt_q, period_cnt_d;

  logic       accept;
  logic       apply;
  logic [7:0] eff_duty;
  logic       act;
  logic       seq_bad;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (duty_valid) state_d = StPending;
      StPending: if (cnt_wrap)   state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    duty_ready = (state_q == StIdle);
    accept     = duty_valid & duty_ready;
    apply      = (state_q == StPending) & cnt_wrap;
  end

  // A duty applied at this wrap must already govern the count-0 compare.
  always_comb begin
    pending_d     = accept ? duty_data : pending_q;
    active_duty_d = apply ? pending_q : active_duty_q;
    eff_duty      = apply ? pending_q : active_duty_q;
    act           = (cnt_in < eff_duty);
    pwm_d         = en ? (act ^ IdleLvl) : IdleLvl;
    applied_d     = apply;
    period_cnt_d  = period_cnt_q + PCNT_W'(cnt_wrap);
    armed_d       = armed_q | cnt_wrap;
    seq_bad       = (cnt_in != prev_cnt_q + 8'd1) || (cnt_wrap != (cnt_in == 8'd0));
    sync_err_d    = sync_err_q | (armed_q & seq_bad);
    prev_cnt_d    = cnt_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q     <= 8'd0;
      active_duty_q <= DUTY_INIT;
      prev_cnt_q    <= 8'd0;
      pwm_q         <= IdleLvl;
      applied_q     <= 1'b0;
      sync_err_q    <= 1'b0;
      armed_q       <= 1'b0;
      period_cnt_q  <= '0;
    end else begin
      pending_q     <= pending_d;
      active_duty_q <= active_duty_d;
      prev_cnt_q    <= prev_cnt_d;
      pwm_q         <= pwm_d;
      applied_q     <= applied_d;
      sync_err_q    <= sync_err_d;
      armed_q       <= armed_d;
      period_cnt_q  <= period_cnt_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign applied    = applied_q;
  assign period_cnt = period_cnt_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_pwm_cmp8.sv
// Bench for pwm_cmp8: two instances (active-high / active-low) share stimulus and are checked
// every cycle against a behavioural model, plus duty tables and corner sequences.
module tb_pwm_cmp8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] cnt = 8'h01;
  logic       wrap = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] dd = 8'h00;

  logic        rdy0, pwm0, app0, err0;
  logic [15:0] pc0;
  logic        rdy1, pwm1, app1, err1;
  logic [3:0]  pc1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_cmp8 #(.ACTIVE_HIGH(1'b1), .DUTY_INIT(8'd0), .PCNT_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .cnt_in(cnt), .cnt_wrap(wrap),
    .duty_valid(dv), .duty_data(dd), .duty_ready(rdy0), .pwm_out(pwm0),
    .applied(app0), .period_cnt(pc0), .sync_err(err0)
  );

  pwm_cmp8 #(.ACTIVE_HIGH(1'b0), .DUTY_INIT(8'd255), .PCNT_W(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .cnt_in(cnt), .cnt_wrap(wrap),
    .duty_valid(dv), .duty_data(dd), .duty_ready(rdy1), .pwm_out(pwm1),
    .applied(app1), .period_cnt(pc1), .sync_err(err1)
  );

  // Reference model state, one slot per instance.
  bit          m_ah[2]   = '{1'b1, 1'b0};
  logic [7:0]  m_init[2] = '{8'd0, 8'd255};
  int unsigned m_pw[2]   = '{16, 4};
  bit          m_pv[2], m_pwm[2], m_app[2], m_err[2], m_arm[2];
  logic [7:0]  m_pend[2], m_act[2], m_prev[2];
  int unsigned m_pc[2];

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_step(input int i);
    logic [7:0] eff;
    bit act;
    if (!reset_n) begin
      m_pv[i] = 0; m_pend[i] = 8'd0; m_act[i] = m_init[i]; m_pwm[i] = !m_ah[i];
      m_app[i] = 0; m_err[i] = 0; m_arm[i] = 0; m_pc[i] = 0; m_prev[i] = 8'd0;
    end else begin
      eff      = (m_pv[i] && wrap) ? m_pend[i] : m_act[i];
      act      = (int'(cnt) < int'(eff));
      m_pwm[i] = en ? (act == m_ah[i]) : !m_ah[i];
      m_app[i] = m_pv[i] && wrap;
      if (m_arm[i] && ((int'(cnt) != (int'(m_prev[i]) + 1) % 256) || (wrap != (cnt == 8'd0))))
        m_err[i] = 1;
      if (wrap) begin
        m_arm[i] = 1;
        m_pc[i]  = (m_pc[i] + 1) % (32'd1 << m_pw[i]);
      end
      m_prev[i] = cnt;
      if (m_pv[i]) begin
        if (wrap) begin
          m_act[i] = m_pend[i];
          m_pv[i]  = 0;
        end
      end else if (dv) begin
        m_pend[i] = dd;
        m_pv[i]   = 1;
      end
    end
  endtask

  // One clock: model and DUTs see the same pre-edge inputs, then the counter advances.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    check("cyc_dut0", 32'({rdy0, pwm0, app0, err0, pc0}),
          32'({!m_pv[0], m_pwm[0], m_app[0], m_err[0], 16'(m_pc[0])}));
    check("cyc_dut1", 32'({rdy1, pwm1, app1, err1, pc1}),
          32'({!m_pv[1], m_pwm[1], m_app[1], m_err[1], 4'(m_pc[1])}));
    dv   = 1'b0;
    cnt  = cnt + 8'd1;
    wrap = (cnt == 8'd0);
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    for (int k = 0; k < 300 && cnt != v; k++) cycle();
  endtask

  task automatic wait_applied(input string nm, output int k);
    k = 0;
    while (!app0 && k < 300) begin
      cycle();
      k++;
    end
    check(nm, 32'(k < 300), 32'd1);
  endtask

  task automatic count_period(output int a0, output int a1);
    a0 = 0;
    a1 = 0;
    repeat (256) begin
      cycle();
      a0 += int'(pwm0);
      a1 += int'(!pwm1);
    end
  endtask

  typedef struct {
    logic [7:0] duty;
    int         exp_act;
  } vec_t;

  initial begin
    vec_t vt[5];
    int a0, a1, k, p;

    vt[0] = '{8'd64, 64};
    vt[1] = '{8'd0, 0};
    vt[2] = '{8'd255, 255};
    vt[3] = '{8'd1, 1};
    vt[4] = '{8'd200, 200};

    // Reset state
    repeat (3) cycle();
    check("rst_pwm0", 32'(pwm0), 32'd0);
    check("rst_pwm1", 32'(pwm1), 32'd1);
    check("rst_ready", 32'(rdy0), 32'd1);
    check("rst_pcnt", 32'(pc0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);

    // T1: three idle periods with DUTY_INIT=0
    cnt = 8'h01;
    wrap = 1'b0;
    reset_n = 1'b1;
    a0 = 0;
    repeat (768) begin
      cycle();
      a0 += int'(pwm0);
    end
    check("t1_idle", 32'(a0), 32'd0);
    check("t1_pcnt", 32'(pc0), 32'd3);
    check("t1_err", 32'(err0), 32'd0);

    // Duty table: offer mid-period, wait for apply, count active cycles in a full period
    foreach (vt[i]) begin
      wait_cnt(8'h40);
      dd = vt[i].duty;
      dv = 1'b1;
      cycle();
      check("tbl_acc_ready", 32'(rdy0), 32'd0);
      wait_applied("tbl_apply_wait", k);
      count_period(a0, a1);
      check("tbl_act_hi", 32'(a0), 32'(vt[i].exp_act));
      check("tbl_act_lo", 32'(a1), 32'(vt[i].exp_act));
    end

    // T3: offer coincident with wrap goes to next wrap; second offer ignored
    wait_cnt(8'h00);
    check("t3_wrap", 32'(wrap), 32'd1);
    dd = 8'd128;
    dv = 1'b1;
    cycle();
    check("t3_acc", 32'(rdy0), 32'd0);
    dd = 8'd7;
    dv = 1'b1;
    cycle();
    check("t3_busy", 32'(rdy0), 32'd0);
    wait_applied("t3_apply_wait", k);
    check("t3_apply_lat", 32'(k), 32'd255);
    count_period(a0, a1);
    check("t3_act_hi", 32'(a0), 32'd128);
    check("t3_act_lo", 32'(a1), 32'd128);

    // T5: disable across a wrap
    wait_cnt(8'hC0);
    p = int'(pc0);
    en = 1'b0;
    a0 = 0;
    a1 = 0;
    repeat (100) begin
      cycle();
      a0 += int'(pwm0);
      a1 += int'(!pwm1);
    end
    check("t5_idle_hi", 32'(a0), 32'd0);
    check("t5_idle_lo", 32'(a1), 32'd0);
    check("t5_pcnt", 32'(pc0), 32'(p + 1));
    en = 1'b1;
    count_period(a0, a1);
    check("t5_act_hi", 32'(a0), 32'd128);

    // Reset while pending: pending dropped, active duty back to DUTY_INIT
    wait_cnt(8'h20);
    dd = 8'd50;
    dv = 1'b1;
    cycle();
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    check("rp_ready", 32'(rdy0), 32'd1);
    count_period(a0, a1);
    check("rp_act_hi", 32'(a0), 32'd0);
    check("rp_act_lo", 32'(a1), 32'd255);

    // T6: skip a count after arming
    check("t6_pre_err", 32'(err0), 32'd0);
    wait_cnt(8'h10);
    cycle();
    cnt = 8'h12;
    cycle();
    check("t6_err0", 32'(err0), 32'd1);
    check("t6_err1", 32'(err1), 32'd1);
    repeat (300) cycle();
    check("t6_held", 32'(err0), 32'd1);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check("t6_clr", 32'(err0), 32'd0);
    repeat (20) cycle();
    check("t6_clr_hold", 32'(err0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
